multibyte_addsub_seq: RTL and testbench
=======================================

MULTIBYTE_ADDSUB_SEQ -- requirements
Module: multibyte_addsub_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the number of byte slices per operand (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand request valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have ports op_a and op_b, input, 8*NBYTES, operands.
REQ-007 SHALL have port op_sub, input, 1: 1 = subtract (op_a - op_b), 0 = add.
REQ-008 SHALL have ports add_a and add_b (output, 8), add_c_in (output, 1) and add_sel (output, 1), which drive the external 8-bit add/sub stage.
REQ-009 SHALL have ports add_sum (input, 8), add_c_out (input, 1) and add_ovf (input, 1), which return the stage's combinational result; add_c_out is a borrow when add_sel=1.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have ports res (output, 8*NBYTES), res_carry (output, 1; carry for add, borrow for subtract) and res_ovf (output, 1; signed overflow).

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid and in_ready are both 1, latching op_a, op_b and op_sub, clearing the byte index, and moving to RUN.
REQ-015 In RUN, SHALL drive add_a = op_a byte[idx], add_b = op_b byte[idx] and add_sel = op_sub, all from registers.
REQ-016 In RUN, add_c_in SHALL equal op_sub when idx=0, and otherwise the registered chain carry.
REQ-017 Each RUN cycle SHALL store add_sum into res byte[idx], set chain carry = add_c_out XOR op_sub (the raw carry), and increment idx.
REQ-018 On the RUN cycle with idx = NBYTES-1, SHALL also latch res_carry = add_c_out and res_ovf = add_ovf, then move to DONE.
REQ-019 Latency: a request accepted on edge t SHALL produce out_valid=1 after edge t+NBYTES; throughput is one operation per NBYTES+2 cycles when out_ready is held at 1.
REQ-020 In DONE, SHALL hold out_valid=1 with res, res_carry and res_ovf stable until out_ready=1, then move to IDLE on that edge.
REQ-021 in_valid and any operand changes during RUN or DONE SHALL be ignored.
REQ-022 Outside RUN, add_a, add_b, add_c_in and add_sel SHALL be 0.
REQ-023 When idx reaches NBYTES-1 it SHALL NOT wrap back to 0 within the same operation.

Reset
REQ-024 While reset=1 at a clock edge, the FSM SHALL go to IDLE, and idx, chain carry, res, res_carry, res_ovf and out_valid SHALL all be cleared to 0; in_ready SHALL be 1 after that edge.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse; reset SHALL take priority over in_valid and out_ready.

Configuration
REQ-026 With macro ADDSUB_SAT_EN defined, on the final byte when add_ovf=1, res SHALL be saturated: 0 followed by all 1s (max positive) if op_a's MSB is 0, else 1 followed by all 0s (min negative); res_ovf SHALL still be 1.
REQ-027 Without ADDSUB_SAT_EN, res SHALL be the wrapped two's-complement result and no saturation logic SHALL be present.

Verification (NBYTES=4)
REQ-028 Add 0x000000FF + 0x00000001 -> res=0x00000100, res_carry=0, res_ovf=0, out_valid exactly 4 cycles after the accept edge.
REQ-029 Add 0x7FFFFFFF + 0x00000001 -> res_ovf=1; res=0x80000000 without the macro, 0x7FFFFFFF with ADDSUB_SAT_EN.
REQ-030 Subtract 0x00000000 - 0x00000001 -> res=0xFFFFFFFF, res_carry=1, res_ovf=0; subtract 0x80000000 - 0x00000001 -> res_ovf=1, res=0x7FFFFFFF without the macro, 0x80000000 with it.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and op_a -> res stable, in_ready=0, no new operation accepted; one cycle after out_ready=1, in_ready=1.
REQ-032 Assert reset when idx=2 -> next cycle in_ready=1, out_valid=0, all add_* outputs 0; a following add 0x00000003 + 0x00000004 -> res=0x00000007.

Source files
------------

// File: rtl/multibyte_addsub_seq_if.sv
// Bus bundle for multibyte_addsub_seq: request/response handshakes plus the
// byte-wide link to the external 8-bit add/sub stage.
interface multibyte_addsub_seq_if #(
    parameter int NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   op_a;
    logic [8*NBYTES-1:0]   op_b;
    logic                  op_sub;
    logic [7:0]            add_a;
    logic [7:0]            add_b;
    logic                  add_c_in;
    logic                  add_sel;
    logic [7:0]            add_sum;
    logic                  add_c_out;
    logic                  add_ovf;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   res;
    logic                  res_carry;
    logic                  res_ovf;

    modport slave (
        input  in_valid, op_a, op_b, op_sub, add_sum, add_c_out, add_ovf, out_ready,
        output in_ready, add_a, add_b, add_c_in, add_sel, out_valid, res, res_carry, res_ovf
    );

    modport master (
        output in_valid, op_a, op_b, op_sub, add_sum, add_c_out, add_ovf, out_ready,
        input  in_ready, add_a, add_b, add_c_in, add_sel, out_valid, res, res_carry, res_ovf
    );
endinterface

// File: rtl/multibyte_addsub_seq.sv
// Sequential NBYTES-wide add/subtract built on one external 8-bit stage, one byte per cycle.
// Optional saturation on signed overflow is enabled with macro ADDSUB_SAT_EN.
module multibyte_addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multibyte_addsub_seq_if.slave   bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [W-1:0]     a_reg, a_next;
    logic [W-1:0]     b_reg, b_next;
    logic             sub_reg, sub_next;
    logic             carry_reg, carry_next;
    logic [W-1:0]     res_reg, res_next;
    logic             res_carry_reg, res_carry_next;
    logic             res_ovf_reg, res_ovf_next;

    logic             running;
    logic             last_byte;
    logic [W-1:0]     res_run;
    logic [W-1:0]     res_final;

    assign running   = (state_reg == RUN);
    assign last_byte = (idx_reg == LAST_IDX);

    // Merge the stage's sum into the byte slot selected by idx.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign res_run[gi*8 +: 8] = (idx_reg == IDX_W'(gi)) ? bus.add_sum : res_reg[gi*8 +: 8];
        end
    endgenerate

`ifdef ADDSUB_SAT_EN
    logic [W-1:0] sat_word;
    assign sat_word  = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign res_final = (last_byte && bus.add_ovf) ? sat_word : res_run;
`else
    assign res_final = res_run;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            res_reg       <= '0;
            res_carry_reg <= 1'b0;
            res_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            sub_reg       <= sub_next;
            carry_reg     <= carry_next;
            res_reg       <= res_next;
            res_carry_reg <= res_carry_next;
            res_ovf_reg   <= res_ovf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        sub_next       = sub_reg;
        carry_next     = carry_reg;
        res_next       = res_reg;
        res_carry_next = res_carry_reg;
        res_ovf_next   = res_ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.op_a;
                    b_next     = bus.op_b;
                    sub_next   = bus.op_sub;
                    idx_next   = '0;
                    carry_next = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                res_next   = res_final;
                // Chain carry is kept in raw (non-inverted) form for either operation.
                carry_next = bus.add_c_out ^ sub_reg;
                if (last_byte) begin
                    res_carry_next = bus.add_c_out;
                    res_ovf_next   = bus.add_ovf;
                    state_next     = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.res       = res_reg;
    assign bus.res_carry = res_carry_reg;
    assign bus.res_ovf   = res_ovf_reg;
    assign bus.add_a     = running ? a_reg[{idx_reg, 3'b000} +: 8] : 8'h00;
    assign bus.add_b     = running ? b_reg[{idx_reg, 3'b000} +: 8] : 8'h00;
    assign bus.add_sel   = running & sub_reg;
    assign bus.add_c_in  = running & ((idx_reg == '0) ? sub_reg : carry_reg);
endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Directed bench for multibyte_addsub_seq with a behavioural 8-bit add/sub stage and a result scoreboard.
module tb_multibyte_addsub_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multibyte_addsub_seq_if #(.NBYTES(NB)) bus ();
    multibyte_addsub_seq #(.NBYTES(NB)) dut (.clk(clk), .reset(reset), .bus(bus));

    // External stage: sum = a + (sel ? ~b : b) + c_in; c_out is a borrow when subtracting.
    logic [7:0] stage_b;
    logic [8:0] stage_full;
    always_comb begin
        stage_b       = bus.add_sel ? ~bus.add_b : bus.add_b;
        stage_full    = {1'b0, bus.add_a} + {1'b0, stage_b} + {8'h00, bus.add_c_in};
        bus.add_sum   = stage_full[7:0];
        bus.add_c_out = stage_full[8] ^ bus.add_sel;
        bus.add_ovf   = (bus.add_a[7] == stage_b[7]) && (stage_full[7] != bus.add_a[7]);
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        logic [W:0] full;
        full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.res = full[W-1:0];
        e.c   = full[W];
        if (sub) e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        else     e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
`ifdef ADDSUB_SAT_EN
        if (e.v) e.res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return e;
    endfunction

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        check("in_ready_idle", {31'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        sb.push_back(model(a, b, sub));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = ~a;
        bus.op_b     = ~b;
        bus.op_sub   = ~sub;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int lat;
        logic [7:0] a0;
        accept(a, b, sub);
        a0 = a[7:0];
        check("add_a_byte0", {24'd0, bus.add_a}, {24'd0, a0});
        check("add_c_in_byte0", {31'd0, bus.add_c_in}, {31'd0, sub});
        lat = 0;
        while (!bus.out_valid && lat < 3 * NB) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, NB);
    endtask

    task automatic finish_op(input int hold, input string tag);
        logic [W-1:0] snap;
        exp_t e;
        snap = bus.res;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.op_a     = $urandom;
            @(posedge clk);
            #1;
            check("hold_res_stable", bus.res, snap);
            check("hold_in_ready", {31'd0, bus.in_ready}, 0);
            check("hold_out_valid", {31'd0, bus.out_valid}, 1);
        end
        bus.in_valid = 1'b0;
        check("out_valid", {31'd0, bus.out_valid}, 1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_res"}, bus.res, e.res);
            check({tag, "_carry"}, {31'd0, bus.res_carry}, {31'd0, e.c});
            check({tag, "_ovf"}, {31'd0, bus.res_ovf}, {31'd0, e.v});
            $display("txn %s res=%h carry=%b ovf=%b", tag, bus.res, bus.res_carry, bus.res_ovf);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_in_ready", {31'd0, bus.in_ready}, 1);
        check("post_out_valid", {31'd0, bus.out_valid}, 0);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_res", bus.res, 0);
        check("rst_flags", {30'd0, bus.res_carry, bus.res_ovf}, 0);
        check("rst_add_bus", {14'd0, bus.add_a, bus.add_b, bus.add_c_in, bus.add_sel}, 0);
        reset = 1'b0;

        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        finish_op(0, "add_ff_1");
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        finish_op(0, "add_ovf");
        start_op(32'h0000_0000, 32'h0000_0001, 1'b1);
        finish_op(0, "sub_0_1");
        start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        finish_op(0, "sub_ovf");
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        finish_op(5, "add_hold");
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op(1, "add_ff_ff");
        start_op(32'h1234_5678, 32'h1234_5679, 1'b1);
        finish_op(0, "sub_mid");

        // Abort mid-operation with reset while idx=2.
        accept(32'hA5A5_1357, 32'h0101_0101, 1'b0);
        void'(sb.pop_back());
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("add_a_byte2", {24'd0, bus.add_a}, 32'h0000_00A5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_in_ready", {31'd0, bus.in_ready}, 1);
        check("abort_out_valid", {31'd0, bus.out_valid}, 0);
        check("abort_add_bus", {14'd0, bus.add_a, bus.add_b, bus.add_c_in, bus.add_sel}, 0);
        seen = 0;
        for (int i = 0; i < NB + 2; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        $display("txn abort_reset done");

        start_op(32'h0000_0003, 32'h0000_0004, 1'b0);
        finish_op(0, "add_3_4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
